// File: rtl/q_pkg.sv
// Shared fixed-point constants, per-stage pipeline records and helpers for the
// Q-learning update datapath (signed Q8.8 words).
package q_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC   = 8;
  localparam int TD_W   = 18;
  localparam int ACC_W  = 20;

  localparam logic [DATA_W-1:0]        Q_ONE   = 16'h0100;
  localparam logic signed [DATA_W-1:0] Q_MAX   = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] Q_MIN   = 16'sh8000;
  localparam logic signed [ACC_W-1:0]  ACC_MAX = 20'sh07FFF;
  localparam logic signed [ACC_W-1:0]  ACC_MIN = 20'shF8000;

  typedef struct packed {
    logic              valid;
    logic [3:0]        state;
    logic [3:0]        action;
    logic [DATA_W-1:0] q_sa;
    logic [DATA_W-1:0] reward;
    logic [DATA_W-1:0] gamma;
    logic [DATA_W-1:0] alpha;
    logic              terminal;
  } s1_t;

  typedef struct packed {
    logic              valid;
    logic [3:0]        state;
    logic [3:0]        action;
    logic [DATA_W-1:0] q_sa;
    logic [DATA_W-1:0] reward;
    logic [DATA_W-1:0] gamma;
    logic [DATA_W-1:0] alpha;
  } s2_t;

  typedef struct packed {
    logic              valid;
    logic [3:0]        state;
    logic [3:0]        action;
    logic [DATA_W-1:0] q_sa;
    logic [DATA_W-1:0] alpha;
    logic [TD_W-1:0]   td;
  } s3_t;

  typedef struct packed {
    logic              valid;
    logic [3:0]        state;
    logic [3:0]        action;
    logic [DATA_W-1:0] q;
  } s4_t;

  function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] x);
    logic [DATA_W-1:0] r;
    if (x > ACC_MAX)      r = Q_MAX;
    else if (x < ACC_MIN) r = Q_MIN;
    else                  r = x[DATA_W-1:0];
    return r;
  endfunction

  // Rates above 1.0 would make the update diverge, so they are pinned to 1.0.
  function automatic logic [DATA_W-1:0] clamp_one(input logic [DATA_W-1:0] v);
    return (v > Q_ONE) ? Q_ONE : v;
  endfunction

endpackage

// File: rtl/max_tree.sv
// Registered signed-max reduction: each output is the max of a contiguous group
// of N_IN/N_OUT inputs; clr loads zeros instead, en holds the register.
module max_tree #(
  parameter int W     = q_pkg::DATA_W,
  parameter int N_IN  = 16,
  parameter int N_OUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [N_IN*W-1:0]    in_vec,
  output logic [N_OUT*W-1:0]   out_vec
);

  localparam int GRP = N_IN / N_OUT;

  logic [N_OUT*W-1:0] max_d, max_q;
  logic signed [W-1:0] best;

  always_comb begin
    max_d = max_q;
    best  = '0;
    if (en) begin
      for (int g = 0; g < N_OUT; g++) begin
        best = $signed(in_vec[g*GRP*W +: W]);
        for (int k = 1; k < GRP; k++) begin
          if ($signed(in_vec[(g*GRP+k)*W +: W]) > best) best = $signed(in_vec[(g*GRP+k)*W +: W]);
        end
        max_d[g*W +: W] = clr ? '0 : best;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_q <= '0;
    else        max_q <= max_d;
  end

  assign out_vec = max_q;

endmodule

// File: rtl/q_update_unit.sv
// Four-stage pipelined Q-learning update:
// Q(s,a) += alpha * (r + gamma * max_a' Q(s',a') - Q(s,a)), saturated to Q8.8.
module q_update_unit #(
  parameter int DATA_W = q_pkg::DATA_W,
  parameter int FRAC   = q_pkg::FRAC,
  parameter int N_ACT  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_state,
  input  logic [3:0]              in_action,
  input  logic                    in_terminal,
  input  logic [DATA_W-1:0]       q_sa,
  input  logic [N_ACT*DATA_W-1:0] q_next_vec,
  input  logic [DATA_W-1:0]       reward,
  input  logic [DATA_W-1:0]       gamma,
  input  logic [DATA_W-1:0]       alpha,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_state,
  output logic [3:0]              out_action,
  output logic [DATA_W-1:0]       out_q
);

  import q_pkg::*;

  localparam int GP_W = 2*DATA_W + 1;
  localparam int AP_W = DATA_W + 1 + TD_W;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  s4_t s4_d, s4_q;

  logic [4*DATA_W-1:0]      s1_max;
  logic [DATA_W-1:0]        s2_maxq;
  logic signed [GP_W-1:0]   gprod;
  logic signed [TD_W-1:0]   td;
  logic signed [AP_W-1:0]   aprod;
  logic signed [ACC_W-1:0]  acc;
  logic                     advance;

  // A full output register that is not being drained freezes the whole pipe.
  assign advance  = !s4_q.valid || out_ready;
  assign in_ready = advance;

  max_tree #(.W(DATA_W), .N_IN(N_ACT), .N_OUT(4)) u_max_s1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (advance),
    .clr    (1'b0),
    .in_vec (q_next_vec),
    .out_vec(s1_max)
  );

  max_tree #(.W(DATA_W), .N_IN(4), .N_OUT(1)) u_max_s2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (advance),
    .clr    (s1_q.terminal),
    .in_vec (s1_max),
    .out_vec(s2_maxq)
  );

  // Arithmetic shifts floor toward -inf; operand ranges fit TD_W/ACC_W exactly.
  always_comb begin
    s1_d  = s1_q;
    s2_d  = s2_q;
    s3_d  = s3_q;
    s4_d  = s4_q;
    gprod = GP_W'($signed({1'b0, s2_q.gamma})) * GP_W'($signed(s2_maxq));
    td    = TD_W'($signed(s2_q.reward)) + TD_W'(gprod >>> FRAC) - TD_W'($signed(s2_q.q_sa));
    aprod = AP_W'($signed({1'b0, s3_q.alpha})) * AP_W'($signed(s3_q.td));
    acc   = ACC_W'($signed(s3_q.q_sa)) + ACC_W'(aprod >>> FRAC);
    if (advance) begin
      s1_d.valid    = in_valid;
      s1_d.state    = in_state;
      s1_d.action   = in_action;
      s1_d.q_sa     = q_sa;
      s1_d.reward   = reward;
      s1_d.gamma    = clamp_one(gamma);
      s1_d.alpha    = clamp_one(alpha);
      s1_d.terminal = in_terminal;

      s2_d.valid    = s1_q.valid;
      s2_d.state    = s1_q.state;
      s2_d.action   = s1_q.action;
      s2_d.q_sa     = s1_q.q_sa;
      s2_d.reward   = s1_q.reward;
      s2_d.gamma    = s1_q.gamma;
      s2_d.alpha    = s1_q.alpha;

      s3_d.valid    = s2_q.valid;
      s3_d.state    = s2_q.state;
      s3_d.action   = s2_q.action;
      s3_d.q_sa     = s2_q.q_sa;
      s3_d.alpha    = s2_q.alpha;
      s3_d.td       = td;

      s4_d.valid    = s3_q.valid;
      s4_d.state    = s3_q.state;
      s4_d.action   = s3_q.action;
      s4_d.q        = saturate(acc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      s4_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      s4_q <= s4_d;
    end
  end

  assign out_valid  = s4_q.valid;
  assign out_state  = s4_q.state;
  assign out_action = s4_q.action;
  assign out_q      = s4_q.q;

endmodule

// File: tb/tb_q_update_unit.sv
// Directed bench for q_update_unit: hand-computed single updates, a stalled
// back-to-back stream checked against a scoreboard, and mid-flight reset.
module tb_q_update_unit;

  localparam int W = 16;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_state;
  logic [3:0]     in_action;
  logic           in_terminal;
  logic [W-1:0]   q_sa;
  logic [N*W-1:0] q_next_vec;
  logic [W-1:0]   reward;
  logic [W-1:0]   gamma;
  logic [W-1:0]   alpha;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     out_state;
  logic [3:0]     out_action;
  logic [W-1:0]   out_q;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]   st;
    logic [3:0]   ac;
    logic [W-1:0] q;
  } exp_t;

  exp_t sb[$];

  q_update_unit #(.DATA_W(W), .FRAC(8), .N_ACT(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .in_action  (in_action),
    .in_terminal(in_terminal),
    .q_sa       (q_sa),
    .q_next_vec (q_next_vec),
    .reward     (reward),
    .gamma      (gamma),
    .alpha      (alpha),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .out_action (out_action),
    .out_q      (out_q)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] fillVec(input logic [W-1:0] v);
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = v;
    return r;
  endfunction

  function automatic logic [N*W-1:0] setLane(input logic [N*W-1:0] vec, input int idx, input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = vec;
    r[idx*W +: W] = v;
    return r;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] qs, input logic [N*W-1:0] nv, input logic [W-1:0] rw,
                               input logic [W-1:0] gm, input logic [W-1:0] al, input logic term,
                               input logic [3:0] st, input logic [3:0] ac);
    in_valid    = 1'b1;
    q_sa        = qs;
    q_next_vec  = nv;
    reward      = rw;
    gamma       = gm;
    alpha       = al;
    in_terminal = term;
    in_state    = st;
    in_action   = ac;
  endtask

  task automatic runSingle(input string tag, input logic [W-1:0] qs, input logic [N*W-1:0] nv,
                           input logic [W-1:0] rw, input logic [W-1:0] gm, input logic [W-1:0] al,
                           input logic term, input logic [3:0] st, input logic [3:0] ac,
                           input logic [W-1:0] expQ);
    @(negedge clk);
    out_ready = 1'b1;
    applyStimulus(qs, nv, rw, gm, al, term, st, ac);
    #1 checkOutput({tag, "_rdy"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput({tag, "_early"}, out_valid, 0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_q"}, out_q, expQ);
    checkOutput({tag, "_state"}, out_state, st);
    checkOutput({tag, "_action"}, out_action, ac);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    int got;
    int stale;
    bit wasStall;
    logic [W-1:0] held;
    exp_t e;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_state    = '0;
    in_action   = '0;
    in_terminal = 1'b0;
    q_sa        = '0;
    q_next_vec  = '0;
    reward      = '0;
    gamma       = '0;
    alpha       = '0;
    out_ready   = 1'b1;

    #12;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_q", out_q, 0);
    checkOutput("rst_state", out_state, 0);
    checkOutput("rst_action", out_action, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    runSingle("basic", 16'h0000, setLane(fillVec(16'h0100), 5, 16'h0200), 16'h0100, 16'h0080, 16'h0080, 1'b0, 4'd3, 4'd5, 16'h0100);
    runSingle("sat_pos", 16'h7F00, fillVec(16'h7FFF), 16'h7FFF, 16'h0100, 16'h0100, 1'b0, 4'd15, 4'd15, 16'h7FFF);
    runSingle("floor", 16'h0000, setLane(fillVec(16'h8000), 0, 16'hFFFF), 16'h0000, 16'h0080, 16'h0100, 1'b0, 4'd1, 4'd0, 16'hFFFF);
    runSingle("terminal", 16'h0000, fillVec(16'h7FFF), 16'h0100, 16'h0100, 16'h0100, 1'b1, 4'd9, 4'd2, 16'h0100);
    runSingle("clamp", 16'h0000, fillVec(16'h0100), 16'h0000, 16'h0300, 16'h0400, 1'b0, 4'd4, 4'd6, 16'h0100);
    runSingle("sat_neg", 16'h8000, fillVec(16'h8000), 16'h8000, 16'h0100, 16'h0100, 1'b0, 4'd7, 4'd8, 16'h8000);
    runSingle("signed_max", 16'h0000, setLane(fillVec(16'hFF00), 7, 16'h0010), 16'h0000, 16'h0100, 16'h0100, 1'b0, 4'd10, 4'd11, 16'h0010);
    runSingle("tie_max", 16'h0000, setLane(setLane(fillVec(16'hF000), 2, 16'h0300), 15, 16'h0300), 16'h0000, 16'h0100, 16'h0100, 1'b0, 4'd12, 4'd13, 16'h0300);
    runSingle("floor_alpha", 16'h0001, fillVec(16'h0000), 16'h0000, 16'h0100, 16'h0080, 1'b0, 4'd2, 4'd14, 16'h0000);

    // Eight back-to-back updates with the sink stalled for three cycles.
    sent = 0;
    got = 0;
    wasStall = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 9);
      if (sent < 8) applyStimulus(16'h0000, fillVec(16'((sent + 1) * 256)), 16'h0000, 16'h0100, 16'h0080, 1'b0, 4'(sent), 4'(15 - sent));
      else in_valid = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        checkOutput("stall_rdy", in_ready, 0);
        if (wasStall) checkOutput("stall_hold", out_q, held);
        held = out_q;
        wasStall = 1'b1;
      end else begin
        wasStall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("stream_extra", got, sent);
        end else begin
          e = sb.pop_front();
          checkOutput("stream_q", out_q, e.q);
          checkOutput("stream_state", out_state, e.st);
          checkOutput("stream_action", out_action, e.ac);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back('{st: 4'(sent), ac: 4'(15 - sent), q: 16'((sent + 1) * 128)});
        sent++;
      end
    end
    in_valid = 1'b0;
    checkOutput("stream_cnt", got, 8);

    // Reset with one result presented and three more in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(16'h0000, fillVec(16'((i + 1) * 256)), 16'h0000, 16'h0100, 16'h0080, 1'b0, 4'(i + 3), 4'(i + 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 checkOutput("pre_rst_valid", out_valid, 1);
    checkOutput("pre_rst_q", out_q, 16'h0080);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_q", out_q, 0);
    checkOutput("mid_rst_state", out_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("post_rst_rdy", in_ready, 1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("post_rst_stale", stale, 0);
    runSingle("post_rst", 16'h0000, setLane(fillVec(16'h0100), 5, 16'h0200), 16'h0100, 16'h0080, 16'h0080, 1'b0, 4'd6, 4'd1, 16'h0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
